// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic TX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered flags and a combinational head word.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       empty_next,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             wr_ok;
    logic             rd_ok;

    // Gating uses the registered full flag, so a pop in the same cycle never frees a slot early.
    assign wr_ok   = push && !full;
    assign rd_ok   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok)
            count_next = count + CNT_W'(1);
        else if (rd_ok && !wr_ok)
            count_next = count - CNT_W'(1);
    end

    assign empty_next = (count_next == '0);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= empty_next;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: FIFO-fed frame serialiser paced by an external baud tick.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            baud_tick,
    input  logic                            wr_en,
    input  logic [DATA_BITS-1:0]            wr_data,
    input  logic                            ovf_clr,
    output logic                            txd,
    output logic                            tbr,
    output logic                            tx_busy,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow
);

    localparam int BIT_W = $clog2(DATA_BITS);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 parity_bit;
    logic                 pop;
    logic                 bit_last;
    logic                 stop_last;
    logic                 idle_next;
    logic                 empty_next;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wr_en),
        .pop        (pop),
        .wr_data    (wr_data),
        .rd_data    (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .empty_next (empty_next),
        .count      (fifo_count)
    );

    assign bit_last  = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
    assign pop       = baud_tick && !fifo_empty &&
                       ((state == IDLE) || (state == STOP && stop_last));
    assign idle_next = ((state == IDLE) && !pop) ||
                       ((state == STOP) && baud_tick && stop_last && fifo_empty);
    assign tx_busy   = (state != IDLE);

    // Datapath: character and its parity are captured when the head is popped.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift      <= head;
            parity_bit <= (^head) ^ 1'(PARITY_ODD);
        end else if (baud_tick && state == DATA) begin
            shift <= shift >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= TX_IDLE_LVL;
            tbr      <= 1'b1;
            overflow <= 1'b0;
        end else begin
            tbr <= idle_next && empty_next;
            if (ovf_clr)
                overflow <= 1'b0;
            else if (wr_en && fifo_full)
                overflow <= 1'b1;

            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            state <= START;
                            txd   <= ~TX_IDLE_LVL;
                        end
                    end
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        txd     <= shift[0];
                    end
                    DATA: begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (!bit_last) begin
                            txd <= shift[1];
                        end else if (PARITY_EN != 0) begin
                            state <= PARITY;
                            txd   <= parity_bit;
                        end else begin
                            state    <= STOP;
                            stop_cnt <= 1'b0;
                            txd      <= TX_IDLE_LVL;
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        txd      <= TX_IDLE_LVL;
                    end
                    STOP: begin
                        if (!stop_last) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else if (!fifo_empty) begin
                            state <= START;
                            txd   <= ~TX_IDLE_LVL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txd   <= TX_IDLE_LVL;
                    end
                endcase
            end
        end
    end

endmodule
